idu_operand_fwd_stage: RTL and testbench



---
 rtl/idu_operand_fwd_stage_if.sv | 34 +++
 rtl/idu_operand_fwd_stage.sv | 132 +++++++++++++
 tb/tb_idu_operand_fwd_stage.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/idu_operand_fwd_stage_if.sv
// rtl/idu_operand_fwd_stage_if.sv - decode-to-IEX operand handshake bundle
// Ports (slave = forwarding stage, master = decode/IEX environment):
//   in_vld/in_ready                instruction handshake from decode
//   rs1_idx/rs2_idx, rs1_vld/rs2_vld  source indices and use flags
//   rf_rs1_data/rf_rs2_data        register-file read data
//   out_vld/out_ready              registered operand handshake towards IEX
//   out_rs1_data/out_rs2_data      resolved operands
interface idu_operand_fwd_stage_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
);
  logic              in_vld;
  logic              in_ready;
  logic [IDX_W-1:0]  rs1_idx;
  logic [IDX_W-1:0]  rs2_idx;
  logic              rs1_vld;
  logic              rs2_vld;
  logic [DATA_W-1:0] rf_rs1_data;
  logic [DATA_W-1:0] rf_rs2_data;
  logic              out_vld;
  logic              out_ready;
  logic [DATA_W-1:0] out_rs1_data;
  logic [DATA_W-1:0] out_rs2_data;

  modport master (
    output in_vld, rs1_idx, rs2_idx, rs1_vld, rs2_vld, rf_rs1_data, rf_rs2_data, out_ready,
    input  in_ready, out_vld, out_rs1_data, out_rs2_data
  );

  modport slave (
    input  in_vld, rs1_idx, rs2_idx, rs1_vld, rs2_vld, rf_rs1_data, rf_rs2_data, out_ready,
    output in_ready, out_vld, out_rs1_data, out_rs2_data
  );
endinterface

// File: rtl/idu_operand_fwd_stage.sv
// rtl/idu_operand_fwd_stage.sv - operand bypass, load-use stall and IEX skid register
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   bus            operand handshake bundle (slave side)
//   byp_data       STAGES*LANES producer results, entry e = s*LANES+l
//   byp_rd         producer destination indices
//   byp_rd_vld     producer writes rd
//   byp_pipe_vld   producer slot holds a live instruction
//   byp_is_load    producer is a load
//   stall_vld      load-use hazard on the current instruction (combinational)
//   stall_cnt      saturating count of stalled cycles
module idu_operand_fwd_stage #(
  parameter int LANES        = 2,
  parameter int STAGES       = 3,
  parameter int DATA_W       = 32,
  parameter int IDX_W        = 5,
  parameter int LOAD_RDY_STG = 1,
  parameter int CNT_W        = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  idu_operand_fwd_stage_if.slave            bus,
  input  logic [STAGES*LANES*DATA_W-1:0]    byp_data,
  input  logic [STAGES*LANES*IDX_W-1:0]     byp_rd,
  input  logic [STAGES*LANES-1:0]           byp_rd_vld,
  input  logic [STAGES*LANES-1:0]           byp_pipe_vld,
  input  logic [STAGES*LANES-1:0]           byp_is_load,
  output logic                              stall_vld,
  output logic [CNT_W-1:0]                  stall_cnt
);

  localparam int ENT = STAGES * LANES;

  typedef enum logic {EMPTY, FULL} state_t;

  // Returns {hazard, operand}. Entries are scanned oldest-first and lane-ascending so
  // the last match left standing is the youngest producer: lowest stage, highest lane.
  // Only that winner matters; an older load hidden behind it never stalls.
  function automatic logic [DATA_W:0] resolve(
    input logic [IDX_W-1:0]      idx,
    input logic                  vld,
    input logic [DATA_W-1:0]     rf,
    input logic [ENT*DATA_W-1:0] d,
    input logic [ENT*IDX_W-1:0]  rd,
    input logic [ENT-1:0]        rdv,
    input logic [ENT-1:0]        pv,
    input logic [ENT-1:0]        ld
  );
    logic              hz;
    logic [DATA_W-1:0] val;
    hz  = 1'b0;
    val = rf;
    for (int s = STAGES - 1; s >= 0; s--) begin
      for (int l = 0; l < LANES; l++) begin
        if (pv[s*LANES+l] && rdv[s*LANES+l] &&
            rd[(s*LANES+l)*IDX_W +: IDX_W] == idx) begin
          val = d[(s*LANES+l)*DATA_W +: DATA_W];
          hz  = ld[s*LANES+l] && (s < LOAD_RDY_STG);
        end
      end
    end
    // x0 and unused sources read as zero and can never hazard.
    if (!vld || idx == '0) begin
      val = '0;
      hz  = 1'b0;
    end
    return {hz, val};
  endfunction

  logic [DATA_W:0]   res1;
  logic [DATA_W:0]   res2;
  logic              accept;
  logic              in_ready;
  state_t            state;
  logic              out_vld_q;
  logic [DATA_W-1:0] out_rs1_q;
  logic [DATA_W-1:0] out_rs2_q;

  always_comb begin
    res1 = resolve(bus.rs1_idx, bus.rs1_vld, bus.rf_rs1_data,
                   byp_data, byp_rd, byp_rd_vld, byp_pipe_vld, byp_is_load);
    res2 = resolve(bus.rs2_idx, bus.rs2_vld, bus.rf_rs2_data,
                   byp_data, byp_rd, byp_rd_vld, byp_pipe_vld, byp_is_load);
  end

  assign stall_vld = bus.in_vld & (res1[DATA_W] | res2[DATA_W]);
  assign in_ready  = ~stall_vld & (~out_vld_q | bus.out_ready);
  assign accept    = bus.in_vld & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_vld_q <= 1'b0;
      out_rs1_q <= '0;
      out_rs2_q <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= FULL;
            out_vld_q <= 1'b1;
            out_rs1_q <= res1[DATA_W-1:0];
            out_rs2_q <= res2[DATA_W-1:0];
          end
        end
        FULL: begin
          if (accept) begin
            // accept implies out_ready here: refill without a bubble
            out_rs1_q <= res1[DATA_W-1:0];
            out_rs2_q <= res2[DATA_W-1:0];
          end else if (bus.out_ready) begin
            state     <= EMPTY;
            out_vld_q <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_vld_q <= 1'b0;
        end
      endcase
      if (stall_vld && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_vld      = out_vld_q;
  assign bus.out_rs1_data = out_rs1_q;
  assign bus.out_rs2_data = out_rs2_q;

endmodule

// File: tb/tb_idu_operand_fwd_stage.sv
// tb/tb_idu_operand_fwd_stage.sv - directed bench with per-cycle reference model
module tb_idu_operand_fwd_stage;

  localparam int LANES  = 2;
  localparam int STAGES = 3;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 5;
  localparam int LRS    = 2;
  localparam int CNT_W  = 16;
  localparam int ENT    = STAGES * LANES;

  logic                   clk;
  logic                   rst;
  logic [ENT*DATA_W-1:0]  byp_data;
  logic [ENT*IDX_W-1:0]   byp_rd;
  logic [ENT-1:0]         byp_rd_vld;
  logic [ENT-1:0]         byp_pipe_vld;
  logic [ENT-1:0]         byp_is_load;
  logic                   stall_vld;
  logic [CNT_W-1:0]       stall_cnt;

  idu_operand_fwd_stage_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) ifc ();

  idu_operand_fwd_stage #(
    .LANES(LANES), .STAGES(STAGES), .DATA_W(DATA_W), .IDX_W(IDX_W),
    .LOAD_RDY_STG(LRS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(ifc),
    .byp_data(byp_data), .byp_rd(byp_rd), .byp_rd_vld(byp_rd_vld),
    .byp_pipe_vld(byp_pipe_vld), .byp_is_load(byp_is_load),
    .stall_vld(stall_vld), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: the first live writer of the index when walking from the youngest
  // stage outward (and the newest lane first) supplies the value.
  function automatic logic [32:0] model_src(input logic [4:0] idx, input logic vld,
                                            input logic [31:0] rf);
    if (!vld || idx == 5'd0) return 33'd0;
    for (int s = 0; s < STAGES; s++) begin
      for (int l = LANES - 1; l >= 0; l--) begin
        int e;
        e = s * LANES + l;
        if (byp_pipe_vld[e] && byp_rd_vld[e] && byp_rd[e*IDX_W +: IDX_W] == idx) begin
          if (byp_is_load[e] && s < LRS) return {1'b1, 32'd0};
          return {1'b0, byp_data[e*DATA_W +: DATA_W]};
        end
      end
    end
    return {1'b0, rf};
  endfunction

  bit          m_ok = 0;
  bit          m_vld;
  logic [31:0] m_rs1, m_rs2;
  int          m_cnt;

  always @(negedge clk) begin
    logic [32:0] r1, r2;
    logic        m_stall, m_ready;
    r1 = model_src(ifc.rs1_idx, ifc.rs1_vld, ifc.rf_rs1_data);
    r2 = model_src(ifc.rs2_idx, ifc.rs2_vld, ifc.rf_rs2_data);
    m_stall = ifc.in_vld && (r1[32] || r2[32]);
    m_ready = !m_stall && (!m_vld || ifc.out_ready);
    if (m_ok) begin
      chk("m_stall_vld", {31'd0, stall_vld}, {31'd0, m_stall});
      chk("m_in_ready", {31'd0, ifc.in_ready}, {31'd0, m_ready});
      chk("m_out_vld", {31'd0, ifc.out_vld}, {31'd0, m_vld});
      if (m_vld) begin
        chk("m_out_rs1", ifc.out_rs1_data, m_rs1);
        chk("m_out_rs2", ifc.out_rs2_data, m_rs2);
      end
      chk("m_stall_cnt", {16'd0, stall_cnt}, m_cnt[31:0]);
    end
    if (rst) begin
      m_ok = 1; m_vld = 0; m_rs1 = 0; m_rs2 = 0; m_cnt = 0;
    end else if (m_ok) begin
      if (ifc.in_vld && m_ready) begin
        m_vld = 1; m_rs1 = r1[31:0]; m_rs2 = r2[31:0];
      end else if (m_vld && ifc.out_ready) begin
        m_vld = 0;
      end
      if (m_stall && m_cnt < 65535) m_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prod();
    byp_data = '0; byp_rd = '0; byp_rd_vld = '0; byp_pipe_vld = '0; byp_is_load = '0;
  endtask

  task automatic set_prod(input int s, input int l, input bit ld, input logic [4:0] rd,
                          input logic [31:0] d);
    int e;
    e = s * LANES + l;
    byp_pipe_vld[e] = 1'b1;
    byp_rd_vld[e]   = 1'b1;
    byp_is_load[e]  = ld;
    byp_rd[e*IDX_W +: IDX_W]   = rd;
    byp_data[e*DATA_W +: DATA_W] = d;
  endtask

  task automatic set_src(input logic [4:0] i1, input bit v1, input logic [4:0] i2, input bit v2);
    ifc.rs1_idx = i1; ifc.rs1_vld = v1; ifc.rs2_idx = i2; ifc.rs2_vld = v2;
  endtask

  initial begin
    rst = 1'b1;
    clear_prod();
    ifc.in_vld = 0; ifc.out_ready = 1;
    set_src(5'd0, 0, 5'd0, 0);
    ifc.rf_rs1_data = 32'h0; ifc.rf_rs2_data = 32'h0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_out_vld", {31'd0, ifc.out_vld}, 32'd0);
    chk("rst_out_rs1", ifc.out_rs1_data, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, ifc.in_ready}, 32'd1);

    // all six producers write x3; stage0 lane1 is youngest
    step();
    for (int s = 0; s < STAGES; s++)
      for (int l = 0; l < LANES; l++)
        set_prod(s, l, 0, 5'd3, 32'h1000_0000 + 32'(s * LANES + l));
    set_prod(0, 1, 0, 5'd3, 32'hBBBB_BBBB);
    set_src(5'd3, 1, 5'd3, 1);
    ifc.in_vld = 1;
    step();
    chk("t1_out_vld", {31'd0, ifc.out_vld}, 32'd1);
    chk("t1_out_rs1", ifc.out_rs1_data, 32'hBBBB_BBBB);
    chk("t1_out_rs2", ifc.out_rs2_data, 32'hBBBB_BBBB);

    // LSU load in stage1 not yet forwardable
    clear_prod();
    set_prod(1, 1, 1, 5'd3, 32'hCCCC_CCCC);
    set_src(5'd3, 1, 5'd3, 0);
    #1;
    chk("t2_stall_vld", {31'd0, stall_vld}, 32'd1);
    chk("t2_in_ready", {31'd0, ifc.in_ready}, 32'd0);
    step();
    chk("t2_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    chk("t2_out_vld", {31'd0, ifc.out_vld}, 32'd0);

    // younger ALU result shadows the load
    set_prod(0, 0, 0, 5'd3, 32'hAAAA_AAAA);
    #1;
    chk("t3_stall_vld", {31'd0, stall_vld}, 32'd0);
    step();
    chk("t3_out_rs1", ifc.out_rs1_data, 32'hAAAA_AAAA);
    chk("t3_out_rs2", ifc.out_rs2_data, 32'd0);

    // unused sources never hazard and read zero
    clear_prod();
    set_prod(0, 0, 1, 5'd3, 32'hDEAD_0003);
    set_src(5'd3, 0, 5'd3, 0);
    #1;
    chk("vld0_stall", {31'd0, stall_vld}, 32'd0);
    step();
    chk("vld0_rs1", ifc.out_rs1_data, 32'd0);

    // load at LOAD_RDY_STG forwards; within stage1 lane1 beats a lane0 load
    clear_prod();
    set_prod(2, 0, 1, 5'd7, 32'h7777_7777);
    set_prod(1, 0, 1, 5'd5, 32'h5050_5050);
    set_prod(1, 1, 0, 5'd5, 32'h5151_5151);
    set_src(5'd7, 1, 5'd5, 1);
    #1;
    chk("bnd_stall", {31'd0, stall_vld}, 32'd0);
    step();
    chk("bnd_rs1", ifc.out_rs1_data, 32'h7777_7777);
    chk("bnd_rs2", ifc.out_rs2_data, 32'h5151_5151);

    // x0 ignores producers writing x0; unmatched rs2 reads the RF
    clear_prod();
    for (int s = 0; s < STAGES; s++)
      for (int l = 0; l < LANES; l++)
        set_prod(s, l, 0, 5'd0, 32'hFFFF_0000 + 32'(s * LANES + l));
    set_src(5'd0, 1, 5'd9, 1);
    ifc.rf_rs1_data = 32'h1111_1111; ifc.rf_rs2_data = 32'h2222_2222;
    step();
    chk("t4_rs1", ifc.out_rs1_data, 32'd0);
    chk("t4_rs2", ifc.out_rs2_data, 32'h2222_2222);

    // backpressure holds operands
    clear_prod();
    set_src(5'd4, 1, 5'd6, 1);
    ifc.rf_rs1_data = 32'h1234_0001; ifc.rf_rs2_data = 32'h1234_0002;
    step();
    ifc.out_ready = 0;
    ifc.rf_rs1_data = 32'h5678_0001; ifc.rf_rs2_data = 32'h5678_0002;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_hold_rdy", {31'd0, ifc.in_ready}, 32'd0);
      chk("t5_hold_rs1", ifc.out_rs1_data, 32'h1234_0001);
      step();
    end
    ifc.out_ready = 1;
    #1;
    chk("t5_rel_rdy", {31'd0, ifc.in_ready}, 32'd1);
    step();
    chk("t5_next_rs1", ifc.out_rs1_data, 32'h5678_0001);
    chk("t5_next_vld", {31'd0, ifc.out_vld}, 32'd1);

    // long stall under backpressure saturates the counter, then reset mid-stall
    set_prod(0, 0, 1, 5'd3, 32'hDEAD_BEEF);
    set_src(5'd3, 1, 5'd0, 0);
    ifc.out_ready = 0;
    repeat (65540) step();
    chk("t6_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
    chk("t6_held_rs1", ifc.out_rs1_data, 32'h5678_0001);
    step();
    chk("t6_sat2", {16'd0, stall_cnt}, 32'h0000_FFFF);
    rst = 1;
    step();
    chk("t6_rst_vld", {31'd0, ifc.out_vld}, 32'd0);
    chk("t6_rst_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("t6_rst_rs1", ifc.out_rs1_data, 32'd0);
    rst = 0;
    ifc.in_vld = 0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
